// File: rtl/riscv_defines.sv
// riscv_defines: shared RV32 load/store funct3 encodings, access sizes and LSU state type
package riscv_defines;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} lsu_state_e;
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return we ? !(f3 inside {F3_SB, F3_SH, F3_SW}) : !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == SZ_H && a[0]) || (f3[1:0] == SZ_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/wb_lsu_align.sv
// wb_lsu_align: byte-lane select, store replication and load extraction/extension
module wb_lsu_align
  import riscv_defines::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] dat_o,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  always_comb begin
    sel = funct3[1:0] == SZ_B ? 4'b0001 << addr_lo : funct3[1:0] == SZ_H ? 4'b0011 << addr_lo : 4'b1111;
    dat_o = funct3[1:0] == SZ_B ? {4{wdata[7:0]}} : funct3[1:0] == SZ_H ? {2{wdata[15:0]}} : wdata;
    sh = bus_rdata >> {addr_lo, 3'b000};
    rdata = funct3 == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
            funct3 == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
            funct3 == F3_LBU ? {24'h0, sh[7:0]} :
            funct3 == F3_LHU ? {16'h0, sh[15:0]} :
            funct3 == F3_LW  ? sh : 32'h0;
  end
endmodule

// File: rtl/wb_lsu_master.sv
// wb_lsu_master: one RV32 load/store request to one Wishbone B4 classic cycle with fault reporting
module wb_lsu_master
  import riscv_defines::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_misalign,
  output logic [31:0] dwb_adr_o,
  output logic [31:0] dwb_dat_o,
  output logic [3:0]  dwb_sel_o,
  output logic        dwb_we_o,
  output logic        dwb_cyc_o,
  output logic        dwb_stb_o,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_ack_i,
  input  logic        dwb_err_i
);
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  lsu_state_e state_q, state_d;
  logic we_q, err_q, mis_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wdata_q, dat_q;
  logic [WD_W-1:0] wd_q;
  logic accept, illegal, misal, timeout, term_err;
  logic [3:0] sel;
  logic [31:0] wdat, ldat;
  wb_lsu_align u_align (
    .funct3(f3_q),
    .addr_lo(addr_q[1:0]),
    .wdata(wdata_q),
    .bus_rdata(dat_q),
    .sel(sel),
    .dat_o(wdat),
    .rdata(ldat)
  );
  always_comb begin
    accept = req_valid && state_q == ST_IDLE;
    illegal = f3_illegal(req_we, req_funct3);
    misal = !illegal && addr_misaligned(req_funct3, req_addr[1:0]);
    timeout = TIMEOUT_CYCLES != 0 && wd_q == WD_LAST;
    term_err = dwb_err_i || timeout;
    state_d = state_q == ST_IDLE ? (accept ? (illegal || misal ? ST_RESP : ST_BUS) : ST_IDLE) :
              state_q == ST_BUS  ? (term_err || dwb_ack_i ? ST_RESP : ST_BUS) : ST_IDLE;
    req_ready = state_q == ST_IDLE;
    dwb_cyc_o = state_q == ST_BUS;
    dwb_stb_o = dwb_cyc_o;
    dwb_adr_o = dwb_cyc_o ? {addr_q[31:2], 2'b00} : 32'h0;
    dwb_sel_o = dwb_cyc_o ? sel : 4'h0;
    dwb_dat_o = dwb_cyc_o ? wdat : 32'h0;
    dwb_we_o = dwb_cyc_o && we_q;
    rsp_valid = state_q == ST_RESP;
    rsp_err = rsp_valid && err_q;
    rsp_misalign = rsp_valid && mis_q;
    rsp_rdata = rsp_valid && !we_q && !err_q && !mis_q ? ldat : 32'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // err beats ack in the same cycle, so data is only captured on a clean ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      f3_q <= 3'b0;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      dat_q <= 32'h0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
      wd_q <= '0;
    end else if (accept) begin
      we_q <= req_we;
      f3_q <= req_funct3;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
      err_q <= illegal;
      mis_q <= misal;
      wd_q <= '0;
    end else if (state_q == ST_BUS) begin
      wd_q <= &wd_q ? wd_q : wd_q + 1'b1;
      err_q <= term_err;
      if (dwb_ack_i && !term_err) dat_q <= dwb_dat_i;
    end else if (state_q == ST_RESP) begin
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master: directed and random load/store transactions against a behavioural memory model
module tb_wb_lsu_master;
  localparam int TO = 8;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic rsp_valid, rsp_err, rsp_misalign;
  logic [31:0] rsp_rdata, dwb_adr_o, dwb_dat_o;
  logic [3:0] dwb_sel_o;
  logic dwb_we_o, dwb_cyc_o, dwb_stb_o;
  logic [31:0] dwb_dat_i = 0;
  logic dwb_ack_i = 0, dwb_err_i = 0;
  int checks = 0, errors = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  always #5 clk = ~clk;

  wb_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_misalign(rsp_misalign),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_sel_o(dwb_sel_o), .dwb_we_o(dwb_we_o),
    .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o),
    .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i), .dwb_err_i(dwb_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preset(input int idx, input logic [31:0] w);
    mem[idx] = w;
    ref_mem[idx] = w;
  endtask

  // Called at a negedge; returns at a negedge one cycle after the response.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int mode, input int waits);
    int n_bytes, off, idx, lat, bus, exp_lat, exp_bus;
    logic legal, mis, fault, done, exp_err;
    logic [31:0] sh, b, exp_rd, exp_dat;
    logic [3:0] exp_sel;
    off = int'(addr[1:0]);
    idx = int'(addr[5:2]);
    n_bytes = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = legal && (off % n_bytes) != 0;
    fault = !legal || mis;
    exp_sel = 4'(((1 << n_bytes) - 1) << off);
    for (int i = 0; i < 4; i++) exp_dat[8*i +: 8] = wdata[8*(i % n_bytes) +: 8];
    exp_err = !legal || (!fault && mode != M_ACK);
    sh = ref_mem[idx] >> (8 * off);
    exp_rd = 32'h0;
    if (!fault && !we && mode == M_ACK) begin
      b = (f3[0] == 1'b0) ? (sh & 32'hFF) : (sh & 32'hFFFF);
      if (f3 == 3'd2) exp_rd = sh;
      else if (f3 == 3'd0) exp_rd = (b >= 32'd128) ? b - 32'd256 : b;
      else if (f3 == 3'd1) exp_rd = (b >= 32'd32768) ? b - 32'd65536 : b;
      else exp_rd = b;
    end
    exp_lat = fault ? 1 : (mode == M_NONE ? TO + 1 : waits + 2);
    exp_bus = fault ? 0 : (mode == M_NONE ? TO : waits + 1);
    if (we && !fault && mode == M_ACK)
      for (int i = off; i < off + n_bytes; i++) ref_mem[idx][8*i +: 8] = wdata[8*(i - off) +: 8];
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0; bus = 0; done = 0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      dwb_ack_i = 0; dwb_err_i = 0; dwb_dat_i = $urandom;
      if (rsp_valid) begin
        done = 1;
        chk("latency", lat, exp_lat);
        chk("bus_cycles", bus, exp_bus);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_misalign", rsp_misalign, mis);
        chk("rsp_rdata", rsp_rdata, exp_rd);
      end else if (dwb_cyc_o) begin
        bus++;
        chk("stb", dwb_stb_o, 1);
        chk("adr", dwb_adr_o, {addr[31:2], 2'b00});
        chk("sel", dwb_sel_o, exp_sel);
        chk("we", dwb_we_o, we);
        if (we) chk("dat_o", dwb_dat_o, exp_dat);
        if (bus > waits) begin
          if (mode == M_ACK) begin
            dwb_ack_i = 1;
            dwb_dat_i = mem[dwb_adr_o[5:2]];
            if (dwb_we_o)
              for (int i = 0; i < 4; i++) if (dwb_sel_o[i]) mem[dwb_adr_o[5:2]][8*i +: 8] = dwb_dat_o[8*i +: 8];
          end else if (mode == M_ERR) dwb_err_i = 1;
          else if (mode == M_BOTH) begin dwb_ack_i = 1; dwb_err_i = 1; end
        end
      end
    end
    chk("rsp_seen", done, 1);
    @(negedge clk);
    dwb_ack_i = 0; dwb_err_i = 0;
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("back_to_idle", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) preset(i, $urandom);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cyc", dwb_cyc_o, 0);
    chk("rst_stb", dwb_stb_o, 0);
    chk("rst_adr", dwb_adr_o, 0);
    chk("rst_sel", dwb_sel_o, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst_n = 1;
    @(negedge clk);
    preset(0, 32'hDEADBEEF);
    xact(0, 3'b010, 32'h0000_0100, 0, M_ACK, 1);
    preset(0, 32'h80123456);
    xact(0, 3'b000, 32'h0000_0103, 0, M_ACK, 1);
    xact(0, 3'b100, 32'h0000_0103, 0, M_ACK, 0);
    preset(0, 32'h11223344);
    xact(1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, M_ACK, 1);
    chk("sh_mem_word", mem[0], 32'hBEEF3344);
    xact(0, 3'b010, 32'h0000_0102, 0, M_ACK, 1);
    xact(0, 3'b001, 32'h0000_0101, 0, M_ACK, 1);
    xact(0, 3'b011, 32'h0000_0100, 0, M_ACK, 1);
    xact(1, 3'b100, 32'h0000_0100, 32'h1234, M_ACK, 1);
    xact(0, 3'b010, 32'h0000_0104, 0, M_ERR, 0);
    xact(0, 3'b101, 32'h0000_0106, 0, M_BOTH, 2);
    xact(1, 3'b010, 32'h0000_0108, 32'hCAFEF00D, M_NONE, 0);
    dwb_ack_i = 1; dwb_err_i = 1;
    @(negedge clk);
    chk("spurious_no_rsp", rsp_valid, 0);
    chk("spurious_idle", req_ready, 1);
    dwb_ack_i = 0; dwb_err_i = 0;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h0000_0110;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("pre_reset_cyc", dwb_cyc_o, 1);
    #2 rst_n = 0;
    #1 chk("reset_cyc_drop", dwb_cyc_o, 0);
    chk("reset_stb_drop", dwb_stb_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_rsp", rsp_valid, 0);
    end
    rst_n = 1;
    @(negedge clk);
    xact(0, 3'b010, 32'h0000_0110, 0, M_ACK, 1);
    for (int t = 0; t < 80; t++) begin
      int m;
      m = int'($urandom_range(0, 7));
      xact(1'($urandom), 3'($urandom), $urandom, $urandom, m < 5 ? M_ACK : m - 4, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
